// File: rtl/rfphoenix_pit_pkg.sv
// rfPhoenix_pkg: shared constants and types for the rfphoenix_pit timer block.
//   - register byte offsets within a channel page and the STATUS address
//   - CTRL bit indices
//   - chan_regs_t: per-channel register snapshot, zero-extended to 32 bits
//   - helpers for byte-lane merging and CTRL read-back formatting
package rfPhoenix_pkg;

  localparam logic [3:0] REG_COUNT  = 4'h0;
  localparam logic [3:0] REG_MAX    = 4'h4;
  localparam logic [3:0] REG_ONTIME = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;
  localparam logic [7:0] REG_STATUS = 8'hF0;

  localparam int unsigned CTRL_LOAD = 0;
  localparam int unsigned CTRL_EN   = 1;
  localparam int unsigned CTRL_AUTO = 2;
  localparam int unsigned CTRL_GE   = 3;
  localparam int unsigned CTRL_IE   = 4;

  typedef struct packed {
    logic [31:0] count;
    logic [31:0] max;
    logic [31:0] ontime;
    logic        ie;
    logic        ge;
    logic        auto_rl;
    logic        en;
  } chan_regs_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[i*8 +: 8] = wdat[i*8 +: 8];
    end
    return r;
  endfunction

  // LOAD is self-clearing, so it always reads back as 0.
  function automatic logic [31:0] ctrl_word(input chan_regs_t r);
    return {27'd0, r.ie, r.ge, r.auto_rl, r.en, 1'b0};
  endfunction

endpackage

// File: rtl/rfphoenix_pit_channel.sv
// rfPhoenix_pit_channel: one programmable interval timer channel.
// Holds MAX, ONTIME, CTRL (EN/AUTO/GE/IE) and the down counter; produces the
// registered compare output and a single-cycle terminal-count event.
// Ports:
//   clk_i, rst_i (async, active-low)
//   gate_i        external count gate (used only with RFPHOENIX_PIT_GATE_EN)
//   wr_max_i, wr_ontime_i, wr_ctrl_i  register write strobes from the bus decode
//   sel_i, dat_i  byte lane selects and write data
//   regs_o        register snapshot for read-back
//   out_o         registered EN & (COUNT < ONTIME)
//   event_o       combinational: pending bit should set on this edge
// Macro RFPHOENIX_PIT_GATE_EN enables the GE bit; without it GE stays 0 and
// the tick depends on EN alone.
module rfPhoenix_pit_channel
  import rfPhoenix_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gate_i,
  input  logic        wr_max_i,
  input  logic        wr_ontime_i,
  input  logic        wr_ctrl_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output chan_regs_t  regs_o,
  output logic        out_o,
  output logic        event_o
);

  logic [BITS-1:0] count_q, count_d;
  logic [BITS-1:0] max_q, max_d;
  logic [BITS-1:0] ontime_q, ontime_d;
  logic            en_q, en_d;
  logic            auto_q, auto_d;
  logic            ge_q, ge_d;
  logic            ie_q, ie_d;
  logic            out_q, out_d;
  logic            load;
  logic            tick;

  assign load = wr_ctrl_i & sel_i[0] & dat_i[CTRL_LOAD];
  // ge_q is held at 0 when the gate feature is compiled out, reducing this to EN.
  assign tick = en_q & (~ge_q | gate_i);

  always_comb begin
    count_d  = count_q;
    max_d    = max_q;
    ontime_d = ontime_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ge_d     = ge_q;
    ie_d     = ie_q;
    event_o  = 1'b0;

    if (load) begin
      count_d = max_q;
    end else if (tick) begin
      if (count_q > BITS'(1)) begin
        count_d = count_q - BITS'(1);
      end else if (count_q == BITS'(1)) begin
        count_d = '0;
        event_o = 1'b1;
      end else if (auto_q) begin
        count_d = max_q;
        // With MAX==0 the reload lands on 0 again, so every tick is terminal.
        if (max_q == '0) event_o = 1'b1;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr_max_i)    max_d    = BITS'(merge_bytes(32'(max_q), dat_i, sel_i));
    if (wr_ontime_i) ontime_d = BITS'(merge_bytes(32'(ontime_q), dat_i, sel_i));
    // A CTRL write wins over the one-shot EN clear in the same cycle.
    if (wr_ctrl_i & sel_i[0]) begin
      en_d   = dat_i[CTRL_EN];
      auto_d = dat_i[CTRL_AUTO];
      ie_d   = dat_i[CTRL_IE];
`ifdef RFPHOENIX_PIT_GATE_EN
      ge_d   = dat_i[CTRL_GE];
`else
      ge_d   = 1'b0;
`endif
    end

    // Compare on next-state values so out_o lines up with the COUNT it reflects.
    out_d = en_d & (count_d < ontime_d);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q  <= '0;
      max_q    <= '0;
      ontime_q <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ge_q     <= 1'b0;
      ie_q     <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      max_q    <= max_d;
      ontime_q <= ontime_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      ge_q     <= ge_d;
      ie_q     <= ie_d;
      out_q    <= out_d;
    end
  end

  assign out_o          = out_q;
  assign regs_o.count   = 32'(count_q);
  assign regs_o.max     = 32'(max_q);
  assign regs_o.ontime  = 32'(ontime_q);
  assign regs_o.en      = en_q;
  assign regs_o.auto_rl = auto_q;
  assign regs_o.ge      = ge_q;
  assign regs_o.ie      = ie_q;

endmodule

// File: rtl/rfphoenix_pit.sv
// rfphoenix_pit: multi-channel programmable interval timer on a classic
// cyc/stb/ack bus, address page FF960xxx (decoded externally into cs_i).
// Ports:
//   clk_i, rst_i (async, active-low)
//   cs_i, cyc_i, stb_i, we_i, sel_i[3:0], adr_i[7:0], dat_i[31:0]  bus request
//   ack_o, dat_o[31:0]   bus response (dat_o is 0 whenever ack_o is low)
//   gate_i[NTIMER-1:0]   per-channel count gate
//   out_o[NTIMER-1:0]    per-channel compare outputs (out_o[0] = time slice)
//   irq_o                OR of pending & IE, registered
// Register map: channel n at adr_i[7:4]=n (COUNT 0x0, MAX 0x4, ONTIME 0x8,
// CTRL 0xC); STATUS at 0xF0 (write-1-to-clear pending bits).
// Macro RFPHOENIX_PIT_GATE_EN makes gate_i / CTRL.GE functional.
module rfphoenix_pit
  import rfPhoenix_pkg::*;
#(
  parameter int unsigned NTIMER = 4,
  parameter int unsigned BITS   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  output logic              ack_o,
  input  logic [3:0]        sel_i,
  input  logic [7:0]        adr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  input  logic [NTIMER-1:0] gate_i,
  output logic [NTIMER-1:0] out_o,
  output logic              irq_o
);

  logic              ack_q, ack_d;
  logic              wait_q, wait_d;
  logic [31:0]       dat_q, dat_d;
  logic [NTIMER-1:0] pend_q, pend_d;
  logic              irq_q, irq_d;
  logic              start;
  logic              wr;
  logic [31:0]       rdata;
  logic [NTIMER-1:0] w1c;
  logic [NTIMER-1:0] evt;
  logic [NTIMER-1:0] ie_vec;
  chan_regs_t        regs [NTIMER];

  // wait_q comes out of reset set, so a strobe left high across reset is not
  // treated as a fresh access until it has been seen low.
  assign start  = cs_i & cyc_i & stb_i & ~ack_q & ~wait_q;
  assign wr     = start & we_i;
  assign ack_d  = start | (ack_q & stb_i);
  assign wait_d = wait_q & stb_i;

  for (genvar n = 0; n < NTIMER; n++) begin : g_ch
    logic hit;
    assign hit = wr & (adr_i[7:4] == 4'(n));

    rfPhoenix_pit_channel #(
      .BITS(BITS)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .gate_i     (gate_i[n]),
      .wr_max_i   (hit & (adr_i[3:0] == REG_MAX)),
      .wr_ontime_i(hit & (adr_i[3:0] == REG_ONTIME)),
      .wr_ctrl_i  (hit & (adr_i[3:0] == REG_CTRL)),
      .sel_i      (sel_i),
      .dat_i      (dat_i),
      .regs_o     (regs[n]),
      .out_o      (out_o[n]),
      .event_o    (evt[n])
    );

    assign ie_vec[n] = regs[n].ie;
  end

  always_comb begin
    rdata = '0;
    for (int unsigned n = 0; n < NTIMER; n++) begin
      if (adr_i[7:4] == 4'(n)) begin
        case (adr_i[3:0])
          REG_COUNT:  rdata = regs[n].count;
          REG_MAX:    rdata = regs[n].max;
          REG_ONTIME: rdata = regs[n].ontime;
          REG_CTRL:   rdata = ctrl_word(regs[n]);
          default:    rdata = '0;
        endcase
      end
    end
    if (adr_i == REG_STATUS) rdata = 32'(pend_q);
  end

  assign w1c    = (wr && adr_i == REG_STATUS && sel_i[0]) ? dat_i[NTIMER-1:0] : '0;
  // New events are OR-ed in after the clear so a coincident set wins.
  assign pend_d = (pend_q & ~w1c) | evt;
  assign irq_d  = |(pend_q & ie_vec);
  assign dat_d  = start ? rdata : (ack_d ? dat_q : '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q  <= 1'b0;
      wait_q <= 1'b1;
      dat_q  <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      wait_q <= wait_d;
      dat_q  <= dat_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = irq_q;

endmodule

// File: doc/rfphoenix_pit.md
RFPHOENIX_PIT -- requirements
Module: rfPhoenix_pit

Interface
REQ-001 Parameter NTIMER, default 4, number of timer channels (1..8).
REQ-002 Parameter BITS, default 32, counter/register width (16..32).
REQ-003 clk_i  input  1  system clock; the single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 cs_i  input  1  chip select, driven by decode of address page FF960xxx.
REQ-006 cyc_i, stb_i, we_i  input  1 each  bus cycle, strobe, write enable.
REQ-007 ack_o  output  1  bus acknowledge.
REQ-008 sel_i  input  4  byte lane selects.
REQ-009 adr_i  input  8  register byte address.
REQ-010 dat_i  input  32  write data.
REQ-011 dat_o  output  32  read data, zero whenever ack_o is low.
REQ-012 gate_i  input  NTIMER  per-channel external count gate.
REQ-013 out_o  output  NTIMER  per-channel timer output; out_o[0] is the time-slice source.
REQ-014 irq_o  output  1  OR of enabled pending channel events.

Function
REQ-015 Channel n registers at adr_i[7:4]=n: 0x0 COUNT (read-only), 0x4 MAX, 0x8 ONTIME, 0xC CTRL; register fields are BITS wide, zero-extended on read.
REQ-016 CTRL bits: 0 LOAD (self-clearing, reads 0), 1 EN, 2 AUTO (auto-reload), 3 GE (gate enable), 4 IE (interrupt enable).
REQ-017 Global 0xF0 STATUS: bit n = channel n pending; write-1-to-clear; other offsets and channels >= NTIMER read 0 and ignore writes.
REQ-018 Writes honour sel_i per byte lane; a write occurs on the cycle the access is first seen (cs_i & cyc_i & stb_i & we_i, ack_o low).
REQ-019 ack_o asserts one cycle after cs_i & cyc_i & stb_i and stays high until stb_i falls; it drops in the cycle after stb_i falls.
REQ-020 dat_o is registered and valid while ack_o is high.
REQ-021 Tick for channel n = EN & (~GE | gate_i[n]).
REQ-022 LOAD write: COUNT <= MAX on the next edge; LOAD has priority over a coincident tick.
REQ-023 Tick with COUNT>1: COUNT decrements by 1.
REQ-024 Tick with COUNT==1: COUNT becomes 0 and the pending bit sets.
REQ-025 Tick with COUNT==0: if AUTO, COUNT <= MAX; otherwise COUNT holds 0 and EN clears; auto-reload period is MAX+1 cycles.
REQ-026 MAX==0 with AUTO: the pending bit sets on every tick.
REQ-027 out_o[n] = EN & (COUNT < ONTIME), registered; ONTIME==0 holds the output low.
REQ-028 Pending set and a W1C write in the same cycle: set wins.
REQ-029 irq_o = |(pending & IE), registered, one cycle after the pending bit sets.

Reset
REQ-030 rst_i low clears all COUNT, MAX, ONTIME, CTRL and pending bits, and drives ack_o, dat_o, out_o and irq_o to 0 immediately.
REQ-031 Reset mid-bus-cycle: ack_o drops; a new cycle starts only after stb_i is seen low.

Configuration
REQ-032 Macro RFPHOENIX_PIT_GATE_EN defined: gate_i is functional per REQ-021.
REQ-033 Macro undefined: the gate_i port remains but is ignored, the GE bit reads 0, and tick = EN.

Structure
REQ-034 Package rfPhoenix_pkg holds the register offset constants, the CTRL bit index constants and a channel-register struct typedef.
REQ-035 One sub-module, rfPhoenix_pit_channel (counter, reload, output compare), is instantiated NTIMER times; the bus decode and STATUS logic stay in the top level.

Verification
REQ-036 MAX=4, ONTIME=2, CTRL=LOAD|EN|AUTO -> COUNT sequence 4,3,2,1,0,4; pending sets once per 5 cycles; out_o[0] high while COUNT is 1 or 0.
REQ-037 MAX=3, CTRL=LOAD|EN (no AUTO) -> COUNT reaches 0 and holds; EN reads 0; exactly one pending set.
REQ-038 IE=1 on channel 2, event -> irq_o=1 one cycle later; write 0x4 to 0xF0 -> irq_o=0; a W1C write coincident with a new event -> irq_o stays 1.
REQ-039 GATE_EN build, GE=1, gate_i[1] low for 10 cycles -> COUNT frozen; GATE_EN off -> counts regardless of gate_i.
REQ-040 Read 0x04 after writing 0x12345678 with sel_i=4'b0011 -> 0x00005678; read 0x50 with NTIMER=4 -> 0; ack_o high 1 cycle after stb_i and low 1 cycle after stb_i falls.
REQ-041 Assert rst_i low mid-count with ack_o high -> all outputs 0 asynchronously; after release all registers read 0.
